// File: rtl/one1.sv
// Two-stage threshold network that flags vectors with exactly one input set.
// Hidden neurons fire on popcount thresholds; the output neuron computes H1 - H2.
module one1 #(
  parameter int ACC_W = 8,
  parameter int T_H1  = 1,
  parameter int T_H2  = 2,
  parameter int T_OUT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  output logic out
);

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t W_POS = acc_t'(1);
  localparam acc_t W_NEG = acc_t'(-1);
  localparam acc_t TH_H1 = acc_t'(T_H1);
  localparam acc_t TH_H2 = acc_t'(T_H2);
  localparam acc_t TH_OUT = acc_t'(T_OUT);

  // Binary input times a sign-extended weight.
  function automatic acc_t wterm(
    input logic b,
    input acc_t w
  );
    return b ? w : '0;
  endfunction

  acc_t sum_hid;
  acc_t sum_out;
  logic h1;
  logic h2;

  always_comb begin
    sum_hid = '0;
    sum_hid = wterm(x1, W_POS)
            + wterm(x2, W_POS)
            + wterm(x3, W_POS)
            + wterm(x4, W_POS);
  end

  always_comb begin
    sum_out = '0;
    sum_out = wterm(h1, W_POS)
            + wterm(h2, W_NEG);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h1  <= 1'b0;
      h2  <= 1'b0;
      out <= 1'b0;
    end else begin
      h1  <= (sum_hid >= TH_H1);
      h2  <= (sum_hid >= TH_H2);
      out <= (sum_out >= TH_OUT);
    end
  end

endmodule

// File: tb/tb_one1.sv
// Scoreboard bench for one1: expected decisions queued at stimulus time,
// popped and compared by an independent monitor after each clock edge.
module tb_one1;

  logic clk;
  logic rst_n;
  logic x1, x2, x3, x4;
  logic out;

  int checks;
  int errors;

  logic exp_q[$];

  logic [3:0] prev_x;
  logic       prev_r;
  logic       stim_done;

  one1 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x1   (x1),
    .x2   (x2),
    .x3   (x3),
    .x4   (x4),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the decision after an edge is "exactly one bit set" of the
  // vector sampled one edge earlier, forced low if reset was seen at
  // either of those two edges.
  task automatic apply(input logic [3:0] v, input logic r);
    logic e;
    @(negedge clk);
    {x1, x2, x3, x4} = v;
    rst_n = r;
    e = r && prev_r && ($countones(prev_x) == 1);
    exp_q.push_back(e);
    prev_x = v;
    prev_r = r;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic e;
      e = exp_q.pop_front();
      checks++;
      if (out !== e) begin
        errors++;
        $display("FAIL out t=%0t got=%b want=%b", $time, out, e);
      end
    end
  end

  initial begin
    logic [3:0] singles[4];
    logic [3:0] multis[5];
    checks = 0;
    errors = 0;
    stim_done = 1'b0;
    prev_x = 4'b0000;
    prev_r = 1'b0;
    rst_n = 1'b0;
    {x1, x2, x3, x4} = 4'b0001;

    singles = '{4'b0001, 4'b1000, 4'b0010, 4'b0100};
    multis  = '{4'b0111, 4'b0101, 4'b0110, 4'b1111, 4'b0000};

    apply(4'b0001, 1'b0);
    apply(4'b0001, 1'b0);
    for (int i = 0; i < 4; i++) apply(4'b0001, 1'b1);

    foreach (singles[i]) apply(singles[i], 1'b1);
    foreach (multis[i]) apply(multis[i], 1'b1);

    for (int i = 0; i < 10; i++)
      apply((i % 2 == 0) ? 4'b0001 : 4'b0101, 1'b1);

    for (int i = 0; i < 16; i++) apply(4'(i), 1'b1);

    for (int i = 0; i < 6; i++) apply(4'b1000, 1'b1);
    apply(4'b1000, 1'b0);
    for (int i = 0; i < 6; i++) apply(4'b1000, 1'b1);

    for (int i = 0; i < 300; i++)
      apply(4'($urandom_range(0, 15)),
            ($urandom_range(0, 19) != 0));

    for (int i = 0; i < 3; i++) apply(4'b0000, 1'b1);
    stim_done = 1'b1;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
